// File: rtl/chinx_rr_mux_pkg.sv
// chinx_mux_pkg: shared helpers for the round-robin channel selector.
//   sel_width(n) : width of a channel index for n channels (at least 1 bit)
//   rr_next(i,n) : round-robin pointer successor with an explicit wrap, so
//                  channel counts that are not a power of two wrap correctly
//   ch_idx_t     : wide channel-index carrier; each user narrows it to its
//                  own SEL_W-bit index type.
// No ports (package).
package chinx_mux_pkg;

    localparam int MAX_SEL_W = 16;

    typedef logic [MAX_SEL_W-1:0] ch_idx_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic ch_idx_t rr_next(input ch_idx_t idx, input int n);
        ch_idx_t one;
        one = ch_idx_t'(1);
        return (idx == ch_idx_t'(n - 1)) ? '0 : idx + one;
    endfunction

endpackage

// File: rtl/chinx_rr_mux_if.sv
// chinx_rr_mux_if: bundle of the selector's handshake and payload signals.
//   valid_i [NUM_CH]              per-channel request valid
//   data_i  [NUM_CH][DATA_WIDTH]  per-channel payload, channel k at [k]
//   ready_o [NUM_CH]              per-channel accept (at most one bit set)
//   valid_o / data_o / sel_o      registered output beat and its source index
//   ready_i                       downstream accept
//   last_i / last_o               packet framing, only with CHINX_RR_MUX_LOCK_EN
// Modports: slave = the selector, master = the producers/consumer around it.
interface chinx_rr_mux_if #(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 32
);
    import chinx_mux_pkg::*;

    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0]                 valid_i;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]                 ready_o;
    logic                              valid_o;
    logic [DATA_WIDTH-1:0]             data_o;
    logic [SEL_W-1:0]                  sel_o;
    logic                              ready_i;
`ifdef CHINX_RR_MUX_LOCK_EN
    logic [NUM_CH-1:0]                 last_i;
    logic                              last_o;

    modport slave (
        input  valid_i, data_i, ready_i, last_i,
        output ready_o, valid_o, data_o, sel_o, last_o
    );
    modport master (
        output valid_i, data_i, ready_i, last_i,
        input  ready_o, valid_o, data_o, sel_o, last_o
    );
`else
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, sel_o
    );
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, sel_o
    );
`endif

endinterface

// File: rtl/chinx_rr_arb.sv
// chinx_rr_arb: combinational round-robin pick.
//   req        [NUM_CH]  requesting channels
//   ptr        [SEL_W]   highest-priority channel this cycle
//   gnt_onehot [NUM_CH]  one-hot winner (zero when nothing requests)
//   gnt_idx    [SEL_W]   winner index
//   gnt_any              some channel requests
// The request vector is doubled and shifted down by ptr, so the first set
// bit of the low half is the first requester at or after ptr with wrap.
module chinx_rr_arb
    import chinx_mux_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;

    always_comb begin
        int k;
        k       = 0;
        dbl     = {req, req};
        rot     = NUM_CH'(dbl >> ptr);
        gnt_any = 1'b0;
        gnt_idx = '0;
        // Scan downward so the lowest set offset (closest to ptr) wins.
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                k = int'(ptr) + j;
                if (k >= NUM_CH) begin
                    k = k - NUM_CH;
                end
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
        gnt_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            gnt_onehot[i] = gnt_any && (gnt_idx == SEL_W'(i));
        end
    end

endmodule

// File: rtl/chinx_rr_mux.sv
// chinx_rr_mux: N-channel valid/ready selector with round-robin arbitration
// and a single registered output stage (one-cycle latency, one beat/cycle).
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      chinx_rr_mux_if.slave: valid_i/data_i/ready_o per channel,
//            valid_o/data_o/sel_o/ready_i toward the consumer
// Optional macro CHINX_RR_MUX_LOCK_EN: adds last_i/last_o; after a non-last
// beat from a channel the grant stays locked to it until its last beat.
module chinx_rr_mux
    import chinx_mux_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic          clk_i,
    input logic          rst_n_i,
    chinx_rr_mux_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_CH);

    typedef logic [SEL_W-1:0] sel_t;

    sel_t                  ptr;
    logic [NUM_CH-1:0]     req;
    logic [NUM_CH-1:0]     gnt_onehot;
    sel_t                  gnt_idx;
    logic                  gnt_any;
    logic                  load;
    logic                  accept;
    sel_t                  ptr_next;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    sel_t                  sel_p1;

`ifdef CHINX_RR_MUX_LOCK_EN
    logic                  locked;
    sel_t                  lock_ch;
    logic                  last_p1;

    // While a packet is in flight only its channel may compete.
    always_comb begin
        req = bus.valid_i;
        if (locked) begin
            req          = '0;
            req[lock_ch] = bus.valid_i[lock_ch];
        end
    end
`else
    assign req = bus.valid_i;
`endif

    chinx_rr_arb #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req        (req),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    // Output stage can take a beat when empty or draining this cycle.
    assign load     = ~vld_p1 | bus.ready_i;
    assign accept   = load & gnt_any;
    assign ptr_next = SEL_W'(rr_next(ch_idx_t'(gnt_idx), NUM_CH));

    // ready_o is held low during reset even though requests may be present.
    assign bus.ready_o = (rst_n_i && load) ? gnt_onehot : '0;

    // ---- stage p1: registered output beat ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
`ifdef CHINX_RR_MUX_LOCK_EN
            last_p1 <= 1'b0;
            locked  <= 1'b0;
            lock_ch <= '0;
`endif
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= bus.data_i[gnt_idx];
            sel_p1  <= gnt_idx;
`ifdef CHINX_RR_MUX_LOCK_EN
            last_p1 <= bus.last_i[gnt_idx];
            locked  <= ~bus.last_i[gnt_idx];
            lock_ch <= gnt_idx;
            // Pointer only moves once the packet is complete.
            if (bus.last_i[gnt_idx]) begin
                ptr <= ptr_next;
            end
`else
            ptr     <= ptr_next;
`endif
        end else if (bus.ready_i) begin
            // Drained with nothing new: payload and index keep their value.
            vld_p1  <= 1'b0;
        end
    end

    assign bus.valid_o = vld_p1;
    assign bus.data_o  = data_p1;
    assign bus.sel_o   = sel_p1;
`ifdef CHINX_RR_MUX_LOCK_EN
    assign bus.last_o  = last_p1;
`endif

endmodule

// File: tb/tb_chinx_rr_mux.sv
module tb_chinx_rr_mux;
    import chinx_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    chinx_rr_mux_if #(.NUM_CH(8), .DATA_WIDTH(32)) bus8 ();
    chinx_rr_mux_if #(.NUM_CH(5), .DATA_WIDTH(16)) bus5 ();

    chinx_rr_mux #(.NUM_CH(8), .DATA_WIDTH(32)) dut8 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus8.slave)
    );

    chinx_rr_mux #(.NUM_CH(5), .DATA_WIDTH(16)) dut5 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus5.slave)
    );

    function automatic logic [31:0] pat8(input int k);
        return 32'hA000_0000 + 32'(k);
    endfunction

    function automatic logic [15:0] pat5(input int k);
        return 16'hB000 + 16'(k);
    endfunction

    task automatic idle_inputs();
        bus8.valid_i = '0;
        bus8.ready_i = 1'b1;
        for (int k = 0; k < 8; k++) bus8.data_i[k] = pat8(k);
        bus5.valid_i = '0;
        bus5.ready_i = 1'b1;
        for (int k = 0; k < 5; k++) bus5.data_i[k] = pat5(k);
`ifdef CHINX_RR_MUX_LOCK_EN
        bus8.last_i = '1;
        bus5.last_i = '1;
`endif
    endtask

    // Leaves the bench at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus8.valid_i = 8'hFF;
        bus5.valid_i = 5'h1F;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        total++; if (bus8.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus8.valid_o); end
        total++; if (bus8.data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus8.data_o); end
        total++; if (bus8.sel_o !== 3'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", bus8.sel_o); end
        total++; if (bus8.ready_o !== 8'h00) begin bad++; $display("FAIL reset_ready: got %h want 00", bus8.ready_o); end
        total++; if (bus5.ready_o !== 5'h00) begin bad++; $display("FAIL reset_ready5: got %h want 00", bus5.ready_o); end
`ifdef CHINX_RR_MUX_LOCK_EN
        total++; if (bus8.last_o !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", bus8.last_o); end
`endif
        bus8.valid_i = '0;
        bus5.valid_i = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bus8.valid_i   = 8'h04;
        bus8.data_i[2] = 32'hDEADBEEF;
        bus8.ready_i   = 1'b1;
        #1;
        total++; if (bus8.ready_o !== 8'h04) begin bad++; $display("FAIL single_ready: got %h want 04", bus8.ready_o); end
        @(posedge clk);
        #1;
        total++; if (bus8.valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus8.valid_o); end
        total++; if (bus8.data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", bus8.data_o); end
        total++; if (bus8.sel_o !== 3'd2) begin bad++; $display("FAIL single_sel: got %0d want 2", bus8.sel_o); end
        bus8.valid_i   = '0;
        bus8.data_i[2] = pat8(2);
        @(posedge clk);
        #1;
        total++; if (bus8.valid_o !== 1'b0) begin bad++; $display("FAIL single_drain_valid: got %b want 0", bus8.valid_o); end
        total++; if (bus8.sel_o !== 3'd2) begin bad++; $display("FAIL single_drain_sel: got %0d want 2", bus8.sel_o); end
    endtask

    // All channels request for 10 cycles; ends with output holding ch1, ptr=2.
    task automatic test_round_robin();
        logic [7:0] exp_rdy;
        int         exp_sel;
        do_reset();
        bus8.valid_i = 8'hFF;
        #1;
        total++; if (bus8.ready_o !== 8'h01) begin bad++; $display("FAIL rr_ready_first: got %h want 01", bus8.ready_o); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            exp_sel = i % 8;
            exp_rdy = 8'h01 << ((i + 1) % 8);
            total++; if (bus8.valid_o !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", i, bus8.valid_o); end
            total++; if (bus8.sel_o !== 3'(exp_sel)) begin bad++; $display("FAIL rr_sel[%0d]: got %0d want %0d", i, bus8.sel_o, exp_sel); end
            total++; if (bus8.data_o !== pat8(exp_sel)) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", i, bus8.data_o, pat8(exp_sel)); end
            total++; if (bus8.ready_o !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d]: got %h want %h", i, bus8.ready_o, exp_rdy); end
        end
    endtask

    task automatic test_backpressure();
        bus8.ready_i = 1'b0;
        #1;
        total++; if (bus8.ready_o !== 8'h00) begin bad++; $display("FAIL bp_ready_stall: got %h want 00", bus8.ready_o); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++; if (bus8.valid_o !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus8.valid_o); end
            total++; if (bus8.sel_o !== 3'd1) begin bad++; $display("FAIL bp_hold_sel[%0d]: got %0d want 1", i, bus8.sel_o); end
            total++; if (bus8.data_o !== pat8(1)) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, bus8.data_o, pat8(1)); end
            total++; if (bus8.ready_o !== 8'h00) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %h want 00", i, bus8.ready_o); end
        end
        bus8.ready_i = 1'b1;
        #1;
        total++; if (bus8.ready_o !== 8'h04) begin bad++; $display("FAIL bp_release_ready: got %h want 04", bus8.ready_o); end
        @(posedge clk);
        #1;
        total++; if (bus8.valid_o !== 1'b1) begin bad++; $display("FAIL bp_next_valid: got %b want 1", bus8.valid_o); end
        total++; if (bus8.sel_o !== 3'd2) begin bad++; $display("FAIL bp_next_sel: got %0d want 2", bus8.sel_o); end
        total++; if (bus8.data_o !== pat8(2)) begin bad++; $display("FAIL bp_next_data: got %h want %h", bus8.data_o, pat8(2)); end
        bus8.valid_i = '0;
        @(posedge clk);
        #1;
        total++; if (bus8.valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain_valid: got %b want 0", bus8.valid_o); end
        total++; if (bus8.sel_o !== 3'd2) begin bad++; $display("FAIL bp_drain_sel: got %0d want 2", bus8.sel_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus8.valid_i = 8'h10;
        bus8.ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus8.valid_i = '0;
        total++; if (bus8.valid_o !== 1'b1) begin bad++; $display("FAIL mid_loaded_valid: got %b want 1", bus8.valid_o); end
        total++; if (bus8.sel_o !== 3'd4) begin bad++; $display("FAIL mid_loaded_sel: got %0d want 4", bus8.sel_o); end
        rst_n = 1'b0;
        #2;
        total++; if (bus8.valid_o !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", bus8.valid_o); end
        total++; if (bus8.data_o !== 32'h0) begin bad++; $display("FAIL mid_async_data: got %h want 0", bus8.data_o); end
        total++; if (bus8.sel_o !== 3'd0) begin bad++; $display("FAIL mid_async_sel: got %0d want 0", bus8.sel_o); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus8.valid_o !== 1'b0) begin bad++; $display("FAIL mid_no_replay: got %b want 0", bus8.valid_o); end
        bus8.ready_i = 1'b1;
    endtask

    task automatic test_wrap5();
        int         exp_sel;
        logic [4:0] exp_rdy;
        do_reset();
        bus5.valid_i = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            exp_sel = (i % 2 == 1) ? 4 : 0;
            exp_rdy = 5'b00001 << exp_sel;
            #1;
            total++; if (bus5.ready_o !== exp_rdy) begin bad++; $display("FAIL wrap_ready[%0d]: got %b want %b", i, bus5.ready_o, exp_rdy); end
            @(posedge clk);
            #1;
            total++; if (bus5.sel_o !== 3'(exp_sel)) begin bad++; $display("FAIL wrap_sel[%0d]: got %0d want %0d", i, bus5.sel_o, exp_sel); end
            total++; if (bus5.data_o !== pat5(exp_sel)) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus5.data_o, pat5(exp_sel)); end
            total++; if (bus5.valid_o !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d]: got %b want 1", i, bus5.valid_o); end
        end
        bus5.valid_i = '0;
        @(posedge clk);
        #1;
        total++; if (bus5.valid_o !== 1'b0) begin bad++; $display("FAIL wrap_drain: got %b want 0", bus5.valid_o); end
    endtask

`ifdef CHINX_RR_MUX_LOCK_EN
    task automatic test_lock();
        int         exp_sel [5] = '{1, 1, 1, 3, 0};
        logic       exp_last[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] nxt_vld [5] = '{8'h0B, 8'h0B, 8'h09, 8'h01, 8'h00};
        logic [7:0] exp_rdy;
        do_reset();
        // One beat from ch0 moves the pointer to ch1.
        bus8.valid_i = 8'h01;
        @(posedge clk);
        #1;
        bus8.valid_i = 8'h0B;
        bus8.last_i  = 8'hFD;
        for (int b = 0; b < 5; b++) begin
            exp_rdy = 8'h01 << exp_sel[b];
            #1;
            total++; if (bus8.ready_o !== exp_rdy) begin bad++; $display("FAIL lock_ready[%0d]: got %h want %h", b, bus8.ready_o, exp_rdy); end
            @(posedge clk);
            #1;
            total++; if (bus8.sel_o !== 3'(exp_sel[b])) begin bad++; $display("FAIL lock_sel[%0d]: got %0d want %0d", b, bus8.sel_o, exp_sel[b]); end
            total++; if (bus8.last_o !== exp_last[b]) begin bad++; $display("FAIL lock_last[%0d]: got %b want %b", b, bus8.last_o, exp_last[b]); end
            total++; if (bus8.valid_o !== 1'b1) begin bad++; $display("FAIL lock_valid[%0d]: got %b want 1", b, bus8.valid_o); end
            bus8.valid_i = nxt_vld[b];
            bus8.last_i  = (b == 1) ? 8'hFF : 8'hFD;
            if (b >= 2) bus8.last_i = 8'hFF;
        end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap5();
`ifdef CHINX_RR_MUX_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
